fifo_ctrl: RTL and testbench

- Pointer and status controller for the 384-bit, 8-deep FIFO.
- Accepts push/pop requests and drives the write enable and write/read addresses of the dual-port RAM stage directly downstream of it.
- Reports full/empty, almost-full/almost-empty and occupancy.
- Flags illegal pushes and pops with sticky error bits.

---
 rtl/fifo_ctrl_pkg.sv | 41 ++++
 rtl/fifo_ctrl.sv | 151 +++++++++++++++
 tb/tb_fifo_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ctrl_pkg
// Description : Shared FIFO geometry, default thresholds and the request
//               classification used by the FIFO pointer/status controller.
//               The FIFO wrapper imports the same package, so the RAM and
//               the controller cannot disagree on widths.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_ctrl_pkg;

    // Geometry of the 384-bit, 8-deep FIFO
    localparam int FIFO_DATA_WIDTH = 384;
    localparam int FIFO_ADDR_WIDTH = 3;

    // Default status thresholds for the default depth of 8
    localparam int FIFO_AF_TH = 6;
    localparam int FIFO_AE_TH = 2;

    // What the accepted traffic does to the occupancy in one cycle
    typedef enum logic [1:0] {
        OP_IDLE = 2'd0,   // nothing accepted
        OP_PUSH = 2'd1,   // only a push accepted: occupancy grows
        OP_POP  = 2'd2,   // only a pop accepted: occupancy shrinks
        OP_BOTH = 2'd3    // push and pop accepted: occupancy holds
    } fifo_op_e;

    // Map the accepted push/pop pair onto an occupancy operation
    function automatic fifo_op_e classify_op(input logic push_ok, input logic pop_ok);
        fifo_op_e op;
        case ({push_ok, pop_ok})
            2'b10:   op = OP_PUSH;
            2'b01:   op = OP_POP;
            2'b11:   op = OP_BOTH;
            default: op = OP_IDLE;
        endcase
        return op;
    endfunction

endpackage : fifo_ctrl_pkg
`default_nettype wire

// File: rtl/fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ctrl
// Description : Pointer and status controller for the 384-bit, 8-deep FIFO.
//               Accepts push/pop requests, drives the write enable and the
//               write/read addresses of the downstream dual-port RAM, and
//               reports full/empty, almost-full/almost-empty, occupancy and
//               sticky overflow/underflow errors.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int AF_TH      = FIFO_AF_TH,
    parameter int AE_TH      = FIFO_AE_TH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    input  logic                  clr_err,
    output logic                  w_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    // Occupancy is one bit wider than the pointers so that "depth" fits
    localparam int                c_cw    = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] c_depth = c_cw'(2 ** ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] c_af_th = c_cw'(AF_TH);
    localparam logic [ADDR_WIDTH:0] c_ae_th = c_cw'(AE_TH);
    localparam logic [ADDR_WIDTH:0] c_one   = c_cw'(1);
    localparam logic [ADDR_WIDTH-1:0] c_ptr_one = ADDR_WIDTH'(1);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic                  w_full;
    logic                  w_empty;
    logic                  w_rd_ok;
    logic                  w_wr_ok;
    logic                  w_ovf_set;
    logic                  w_unf_set;
    fifo_op_e              w_op;
    logic [ADDR_WIDTH:0]   w_count_nxt;

    // Status flags come straight from the registered occupancy, so they only
    // change right after a clock edge.
    assign w_full  = (r_count == c_depth);
    assign w_empty = (r_count == '0);

    // A pop needs something to pop. A push needs a free slot, or a slot that
    // is being freed by a pop in the same cycle: the RAM read is asynchronous,
    // so the departing word is consumed before the edge overwrites it.
    assign w_rd_ok = rd & ~w_empty;
    assign w_wr_ok = wr & (~w_full | rd);

    // Rejected requests only raise the sticky error bits
    assign w_ovf_set = wr & ~w_wr_ok;
    assign w_unf_set = rd & w_empty;

    assign w_op = classify_op(w_wr_ok, w_rd_ok);

    // Next occupancy: only one-sided traffic changes it
    always_comb begin
        w_count_nxt = r_count;
        case (w_op)
            OP_PUSH: w_count_nxt = r_count + c_one;
            OP_POP:  w_count_nxt = r_count - c_one;
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointers advance only on accepted traffic; wrap is the natural
    // overflow of the ADDR_WIDTH-bit register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
        end
    end

    // Occupancy register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    // Sticky error bits; a new error in the clearing cycle takes priority
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (w_unf_set) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The RAM shares this reset; keep it from writing while reset is held.
    assign w_en         = w_wr_ok & ~reset;
    assign w_addr       = r_wr_ptr;
    assign r_addr       = r_rd_ptr;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= c_af_th);
    assign almost_empty = (r_count <= c_ae_th);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule : fifo_ctrl
`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_ctrl
// Description : Self-checking bench for fifo_ctrl. A behavioural RAM sits
//               beside the controller like in the FIFO wrapper; a queue-based
//               reference model predicts occupancy, flags, addresses and data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_ctrl;
    import fifo_ctrl_pkg::*;

    localparam int DW    = FIFO_DATA_WIDTH;
    localparam int AW    = FIFO_ADDR_WIDTH;
    localparam int DEPTH = 2 ** AW;
    localparam int AF    = FIFO_AF_TH;
    localparam int AE    = FIFO_AE_TH;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr = 1'b0;
    logic          rd = 1'b0;
    logic          clr_err = 1'b0;
    logic          w_en;
    logic [AW-1:0] w_addr;
    logic [AW-1:0] r_addr;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    logic [DW-1:0] w_data = '0;
    logic [DW-1:0] mem [DEPTH];

    // Reference model state
    logic [DW-1:0] q [$];
    int            m_pushes;
    int            m_pops;
    logic          m_ov;
    logic          m_un;
    logic          exp_wen;
    logic          obs_wen;

    int            n_checks = 0;
    int            n_pass   = 0;

    logic [9:0]    obs_status;
    assign obs_status = {full, empty, almost_full, almost_empty, count, overflow, underflow};

    fifo_ctrl #(.ADDR_WIDTH(AW), .AF_TH(AF), .AE_TH(AE)) dut (
        .clk(clk), .reset(reset), .wr(wr), .rd(rd), .clr_err(clr_err),
        .w_en(w_en), .w_addr(w_addr), .r_addr(r_addr),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Behavioural dual-port RAM: synchronous write, asynchronous read
    always @(posedge clk) begin
        if (w_en) mem[w_addr] <= w_data;
    end

    function automatic logic [9:0] exp_status();
        int n;
        n = q.size();
        return {n == DEPTH, n == 0, n >= AF, n <= AE, 4'(n), m_ov, m_un};
    endfunction

    function automatic logic [AW-1:0] exp_waddr();
        return AW'(m_pushes % DEPTH);
    endfunction

    function automatic logic [AW-1:0] exp_raddr();
        return AW'(m_pops % DEPTH);
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // One clock of stimulus plus the model's view of what it should do
    task automatic step(input logic s_wr, input logic s_rd, input logic s_clr,
                        input logic s_rst, input logic [DW-1:0] s_data);
        int   sz;
        logic wok;
        logic rok;
        @(negedge clk);
        wr = s_wr; rd = s_rd; clr_err = s_clr; reset = s_rst; w_data = s_data;
        #1;
        obs_wen = w_en;
        sz  = q.size();
        rok = s_rd && (sz > 0);
        wok = s_wr && ((sz < DEPTH) || s_rd);
        if (s_rst) begin
            q.delete();
            m_pushes = 0; m_pops = 0; m_ov = 1'b0; m_un = 1'b0; exp_wen = 1'b0;
        end else begin
            exp_wen = wok;
            if (rok) begin void'(q.pop_front()); m_pops++; end
            if (wok) begin q.push_back(s_data); m_pushes++; end
            if (s_wr && !wok) m_ov = 1'b1; else if (s_clr) m_ov = 1'b0;
            if (s_rd && sz == 0) m_un = 1'b1; else if (s_clr) m_un = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        n_checks++;
        if (obs_status !== 10'b0101_0000_00) $display("FAIL reset_status: got %b expected %b", obs_status, 10'b0101_0000_00);
        else n_pass++;
        n_checks++;
        if ({w_addr, r_addr, w_en} !== '0) $display("FAIL reset_addr: got w_addr %0d r_addr %0d w_en %b expected 0 0 0", w_addr, r_addr, w_en);
        else n_pass++;
    endtask

    task automatic test_fill();
        logic [DW-1:0] d;
        step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        for (int k = 1; k <= 9; k++) begin
            d = DW'(k);
            step(1'b1, 1'b0, 1'b0, 1'b0, d);
            n_checks++;
            if (obs_wen !== exp_wen) $display("FAIL fill_wen push %0d: got %b expected %b", k, obs_wen, exp_wen);
            else n_pass++;
            n_checks++;
            if (obs_status !== exp_status()) $display("FAIL fill_status push %0d: got %b expected %b", k, obs_status, exp_status());
            else n_pass++;
        end
        n_checks++;
        if ({count, full, overflow} !== {4'd8, 1'b1, 1'b1}) $display("FAIL fill_overflow: got count %0d full %b ov %b expected 8 1 1", count, full, overflow);
        else n_pass++;
    endtask

    task automatic test_drain();
        step(1'b0, 1'b0, 1'b1, 1'b0, '0);
        for (int k = 1; k <= 9; k++) begin
            if (k <= DEPTH) begin
                n_checks++;
                if (mem[r_addr] !== DW'(k)) $display("FAIL drain_data pop %0d: got %0d expected %0d", k, mem[r_addr][31:0], k);
                else n_pass++;
            end
            step(1'b0, 1'b1, 1'b0, 1'b0, '0);
            n_checks++;
            if (obs_status !== exp_status()) $display("FAIL drain_status pop %0d: got %b expected %b", k, obs_status, exp_status());
            else n_pass++;
        end
        n_checks++;
        if ({empty, underflow, r_addr} !== {1'b1, 1'b1, 3'd0}) $display("FAIL drain_underflow: got empty %b un %b r_addr %0d expected 1 1 0", empty, underflow, r_addr);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [AW-1:0] ea;
        step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, rand_word());
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i <= 6; i++) begin
            ea = AW'((5 + i) % DEPTH);
            n_checks++;
            if (w_addr !== ea) $display("FAIL wrap_waddr %0d: got %0d expected %0d", i, w_addr, ea);
            else n_pass++;
            if (i < 6) step(1'b1, 1'b0, 1'b0, 1'b0, rand_word());
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (mem[r_addr] !== q[0]) $display("FAIL wrap_data %0d: got %h expected %h", i, mem[r_addr][31:0], q[0][31:0]);
            else n_pass++;
            step(1'b1, 1'b1, 1'b0, 1'b0, rand_word());
            n_checks++;
            if (count !== 4'd6) $display("FAIL wrap_count %0d: got %0d expected 6", i, count);
            else n_pass++;
        end
    endtask

    task automatic test_full_both();
        logic [DW-1:0] oldest;
        logic [DW-1:0] d;
        step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, 1'b0, rand_word());
        oldest = q[0];
        n_checks++;
        if (mem[r_addr] !== oldest) $display("FAIL fullboth_oldest: got %h expected %h", mem[r_addr][31:0], oldest[31:0]);
        else n_pass++;
        d = rand_word();
        step(1'b1, 1'b1, 1'b0, 1'b0, d);
        n_checks++;
        if ({count, overflow, obs_wen} !== {4'd8, 1'b0, 1'b1}) $display("FAIL fullboth_status: got count %0d ov %b w_en %b expected 8 0 1", count, overflow, obs_wen);
        else n_pass++;
        n_checks++;
        if (mem[3'd0] !== d) $display("FAIL fullboth_slot: got %h expected %h", mem[3'd0][31:0], d[31:0]);
        else n_pass++;
    endtask

    task automatic test_empty_both();
        step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        step(1'b1, 1'b1, 1'b0, 1'b0, rand_word());
        n_checks++;
        if ({count, underflow, overflow} !== {4'd1, 1'b1, 1'b0}) $display("FAIL emptyboth: got count %0d un %b ov %b expected 1 1 0", count, underflow, overflow);
        else n_pass++;
        n_checks++;
        if (obs_status !== exp_status()) $display("FAIL emptyboth_status: got %b expected %b", obs_status, exp_status());
        else n_pass++;
    endtask

    task automatic test_clr_err();
        step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, 1'b0, rand_word());
        step(1'b1, 1'b0, 1'b0, 1'b0, rand_word());
        step(1'b1, 1'b0, 1'b1, 1'b0, rand_word());
        n_checks++;
        if (overflow !== 1'b1) $display("FAIL clr_set_wins: got %b expected 1", overflow);
        else n_pass++;
        step(1'b0, 1'b0, 1'b1, 1'b0, '0);
        n_checks++;
        if (overflow !== 1'b0) $display("FAIL clr_alone: got %b expected 0", overflow);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, rand_word());
        n_checks++;
        if (count !== 4'd5) $display("FAIL rstmid_pre: got count %0d expected 5", count);
        else n_pass++;
        step(1'b1, 1'b0, 1'b0, 1'b1, rand_word());
        n_checks++;
        if (obs_wen !== 1'b0) $display("FAIL rstmid_wen: got %b expected 0", obs_wen);
        else n_pass++;
        n_checks++;
        if ({count, empty} !== {4'd0, 1'b1}) $display("FAIL rstmid_post: got count %0d empty %b expected 0 1", count, empty);
        else n_pass++;
    endtask

    task automatic test_random();
        logic s_wr;
        logic s_rd;
        logic s_rst;
        int   bias;
        step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < 400; i++) begin
            bias  = (i / 50) % 3;
            s_wr  = ($urandom_range(0, 3) < 1 + bias);
            s_rd  = ($urandom_range(0, 3) < 3 - bias);
            s_rst = ($urandom_range(0, 99) == 0);
            step(s_wr, s_rd, ($urandom_range(0, 7) == 0), s_rst, rand_word());
            n_checks++;
            if (obs_wen !== exp_wen) $display("FAIL rand_wen %0d: got %b expected %b", i, obs_wen, exp_wen);
            else n_pass++;
            n_checks++;
            if (obs_status !== exp_status()) $display("FAIL rand_status %0d: got %b expected %b", i, obs_status, exp_status());
            else n_pass++;
            n_checks++;
            if ({w_addr, r_addr} !== {exp_waddr(), exp_raddr()}) $display("FAIL rand_addr %0d: got w %0d r %0d expected w %0d r %0d", i, w_addr, r_addr, exp_waddr(), exp_raddr());
            else n_pass++;
            if (q.size() > 0) begin
                n_checks++;
                if (mem[r_addr] !== q[0]) $display("FAIL rand_data %0d: got %h expected %h", i, mem[r_addr][31:0], q[0][31:0]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        m_pushes = 0; m_pops = 0; m_ov = 1'b0; m_un = 1'b0;
        exp_wen = 1'b0; obs_wen = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_full_both();
        test_empty_both();
        test_clr_err();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fifo_ctrl
`default_nettype wire
